// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman game: sound sequencer states and
// the collision codes produced by pacman location control.
package pacman_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_CHOMP,
      S_EATGHOST,
      S_DEATH
   } sound_state_t;

   localparam logic [3:0] PILL_CODE_DEFAULT  = 4'd2;
   localparam logic [3:0] POWER_CODE_DEFAULT = 4'd3;

   // Arbitration rank: larger wins, IDLE ranks below every sound.
   function automatic logic [2:0] sound_prio(input sound_state_t s);
      case (s)
         S_DEATH:    return 3'd4;
         S_EATGHOST: return 3'd3;
         S_START:    return 3'd2;
         S_CHOMP:    return 3'd1;
         default:    return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/sound_timer.sv
// Loadable down-counter that saturates at zero; holds the remaining length
// of the active sound request.
module sound_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (count_q != '0)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/sound_event_sequencer.sv
// Turns game events into level-held sound requests with fixed-priority
// arbitration, and flags natural completion of the death sound.
//
// state      | meaning
// S_IDLE     | no sound requested
// S_START    | start jingle held
// S_CHOMP    | pill chomp held (retrigger extends)
// S_EATGHOST | ghost-eaten sound held (retrigger extends)
// S_DEATH    | death sound held, cannot be preempted or retriggered
module sound_event_sequencer
   import pacman_pkg::*;
#(
   parameter int unsigned START_CYCLES    = 200_000_000,
   parameter int unsigned CHOMP_CYCLES    = 12_500_000,
   parameter int unsigned EATGHOST_CYCLES = 25_000_000,
   parameter int unsigned DEATH_CYCLES    = 75_000_000,
   parameter logic [3:0]  PILL_CODE       = PILL_CODE_DEFAULT,
   parameter logic [3:0]  POWER_CODE      = POWER_CODE_DEFAULT
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       game_start,
   input  logic [3:0] collision_type,
   input  logic       ghost_eaten,
   input  logic       pac_death,
   input  logic       mute,
   output logic       sound_start,
   output logic       sound_chomp,
   output logic       sound_eatghost,
   output logic       sound_death,
   output logic       busy,
   output logic       death_done
);

   localparam int unsigned MAX_AB  = (START_CYCLES > CHOMP_CYCLES) ? START_CYCLES : CHOMP_CYCLES;
   localparam int unsigned MAX_CD  = (EATGHOST_CYCLES > DEATH_CYCLES) ? EATGHOST_CYCLES : DEATH_CYCLES;
   localparam int unsigned MAX_DUR = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int          CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

   localparam logic [CW-1:0] START_LOAD    = CW'(START_CYCLES - 1);
   localparam logic [CW-1:0] CHOMP_LOAD    = CW'(CHOMP_CYCLES - 1);
   localparam logic [CW-1:0] EATGHOST_LOAD = CW'(EATGHOST_CYCLES - 1);
   localparam logic [CW-1:0] DEATH_LOAD    = CW'(DEATH_CYCLES - 1);

   sound_state_t  state_q, state_d;
   sound_state_t  evt;
   logic [3:0]    prev_type_q;
   logic          death_done_q, death_done_d;
   logic          chomp_evt;
   logic          accept;
   logic          tmr_load;
   logic [CW-1:0] tmr_load_val;
   logic [CW-1:0] tmr_count;
   logic          tmr_zero;
   logic          at_end;

   sound_timer #(.W(CW)) u_timer (
      .clk      (CLOCK_50),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   assign at_end = (tmr_count == '0);

   always_comb begin
      state_d      = state_q;
      evt          = S_IDLE;
      accept       = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      death_done_d = (state_q == S_DEATH) && tmr_zero;

      chomp_evt = ((collision_type == PILL_CODE) || (collision_type == POWER_CODE))
                  && (collision_type != prev_type_q);

      if (pac_death)        evt = S_DEATH;
      else if (ghost_eaten) evt = S_EATGHOST;
      else if (game_start)  evt = S_START;
      else if (chomp_evt)   evt = S_CHOMP;

      // A finishing sound behaves like IDLE so a waiting event starts with no gap.
      if (evt != S_IDLE) begin
         if ((state_q == S_IDLE) || at_end)
            accept = 1'b1;
         else if (sound_prio(evt) > sound_prio(state_q))
            accept = 1'b1;
         else if ((evt == state_q) && ((evt == S_CHOMP) || (evt == S_EATGHOST)))
            accept = 1'b1;
      end

      if (accept) begin
         state_d  = evt;
         tmr_load = 1'b1;
         case (evt)
            S_START:    tmr_load_val = START_LOAD;
            S_CHOMP:    tmr_load_val = CHOMP_LOAD;
            S_EATGHOST: tmr_load_val = EATGHOST_LOAD;
            S_DEATH:    tmr_load_val = DEATH_LOAD;
            default:    tmr_load_val = '0;
         endcase
      end else if ((state_q != S_IDLE) && at_end) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         prev_type_q  <= '0;
         death_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_type_q  <= collision_type;
         death_done_q <= death_done_d;
      end
   end

   assign sound_start    = (state_q == S_START)    & ~mute;
   assign sound_chomp    = (state_q == S_CHOMP)    & ~mute;
   assign sound_eatghost = (state_q == S_EATGHOST) & ~mute;
   assign sound_death    = (state_q == S_DEATH)    & ~mute;
   assign busy           = (state_q != S_IDLE);
   assign death_done     = death_done_q;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: directed scenarios plus random traffic,
// checked against a priority/duration model of the sound requests.
module tb_sound_event_sequencer;

   localparam int D_START = 5;
   localparam int D_CHOMP = 4;
   localparam int D_EAT   = 6;
   localparam int D_DEATH = 8;

   // model ranks: 0 none, 1 chomp, 2 start, 3 eatghost, 4 death
   localparam int P_CHOMP = 1;
   localparam int P_START = 2;
   localparam int P_EAT   = 3;
   localparam int P_DEATH = 4;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       game_start = 1'b0;
   logic [3:0] collision_type = 4'd0;
   logic       ghost_eaten = 1'b0;
   logic       pac_death = 1'b0;
   logic       mute = 1'b0;
   logic       sound_start, sound_chomp, sound_eatghost, sound_death, busy, death_done;

   logic [5:0] act;
   assign act = {sound_start, sound_chomp, sound_eatghost, sound_death, busy, death_done};

   int         n_checks = 0;
   int         n_fail = 0;
   int         m_cur = 0;
   int         m_rem = 0;
   logic [3:0] m_prev = 4'd0;
   logic       m_done = 1'b0;

   always #5 CLOCK_50 = ~CLOCK_50;

   sound_event_sequencer #(
      .START_CYCLES    (D_START),
      .CHOMP_CYCLES    (D_CHOMP),
      .EATGHOST_CYCLES (D_EAT),
      .DEATH_CYCLES    (D_DEATH),
      .PILL_CODE       (4'd2),
      .POWER_CODE      (4'd3)
   ) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .game_start     (game_start),
      .collision_type (collision_type),
      .ghost_eaten    (ghost_eaten),
      .pac_death      (pac_death),
      .mute           (mute),
      .sound_start    (sound_start),
      .sound_chomp    (sound_chomp),
      .sound_eatghost (sound_eatghost),
      .sound_death    (sound_death),
      .busy           (busy),
      .death_done     (death_done)
   );

   function automatic int dur_of(input int p);
      case (p)
         P_CHOMP: return D_CHOMP;
         P_START: return D_START;
         P_EAT:   return D_EAT;
         default: return D_DEATH;
      endcase
   endfunction

   function automatic logic [5:0] exp_vec();
      return {(m_cur == P_START) && !mute, (m_cur == P_CHOMP) && !mute,
              (m_cur == P_EAT) && !mute, (m_cur == P_DEATH) && !mute,
              m_cur != 0, m_done};
   endfunction

   // Drive one cycle of inputs, clock once, advance the model, settle 1 time unit.
   task automatic step(input bit gs, input bit ge, input bit pd, input logic [3:0] ct,
                       input bit m, input bit rst);
      bit chomp_ev;
      int best;
      game_start = gs; ghost_eaten = ge; pac_death = pd;
      collision_type = ct; mute = m; reset = rst;
      @(posedge CLOCK_50);
      if (rst) begin
         m_cur = 0; m_rem = 0; m_prev = 4'd0; m_done = 1'b0;
      end else begin
         chomp_ev = ((ct == 4'd2) || (ct == 4'd3)) && (ct != m_prev);
         best = pd ? P_DEATH : ge ? P_EAT : gs ? P_START : chomp_ev ? P_CHOMP : 0;
         m_done = (m_cur == P_DEATH) && (m_rem == 1);
         if (best != 0 && (m_cur == 0 || m_rem == 1 || best > m_cur ||
                           (best == m_cur && (best == P_CHOMP || best == P_EAT)))) begin
            m_cur = best;
            m_rem = dur_of(best);
         end else if (m_cur != 0) begin
            m_rem--;
            if (m_rem == 0) m_cur = 0;
         end
         m_prev = ct;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 4'd0, 0, 1);
         n_checks++;
         if (act !== 6'b0) begin
            n_fail++;
            $display("FAIL reset step %0d: got %b expected %b", i, act, 6'b0);
         end
      end
   endtask

   task automatic test_chomp();
      int cnt = 0;
      int first = -1;
      step(0, 0, 0, 4'd0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 4'd2, 0, 0);
         n_checks++;
         if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL chomp step %0d: got %b expected %b", i, act, exp_vec());
         end
         if (sound_chomp) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      n_checks++;
      if (cnt !== D_CHOMP || first !== 0) begin
         n_fail++;
         $display("FAIL chomp_len: got %0d cycles from %0d expected %0d from 0", cnt, first, D_CHOMP);
      end
   endtask

   task automatic test_preempt();
      int eat_cnt = 0;
      int chomp_late = 0;
      for (int i = 0; i < 11; i++) begin
         step(0, i == 2, 0, 4'd3, 0, 0);
         n_checks++;
         if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL preempt step %0d: got %b expected %b", i, act, exp_vec());
         end
         if (i >= 2) begin
            if (sound_eatghost) eat_cnt++;
            if (sound_chomp) chomp_late++;
         end
      end
      n_checks++;
      if (eat_cnt !== D_EAT || chomp_late !== 0) begin
         n_fail++;
         $display("FAIL preempt_len: got eat %0d chomp %0d expected eat %0d chomp 0", eat_cnt, chomp_late, D_EAT);
      end
   endtask

   task automatic test_same_cycle();
      int dcnt = 0;
      int done_at = -1;
      int other = 0;
      for (int i = 1; i <= 11; i++) begin
         step(i == 1, 0, i == 1, 4'd2, 0, 0);
         n_checks++;
         if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL same_cycle step %0d: got %b expected %b", i, act, exp_vec());
         end
         if (sound_death) dcnt++;
         if (death_done && done_at < 0) done_at = i;
         if (sound_start || sound_chomp || sound_eatghost) other++;
      end
      n_checks++;
      if (dcnt !== D_DEATH || done_at !== D_DEATH + 1 || other !== 0) begin
         n_fail++;
         $display("FAIL same_cycle_len: got death %0d done@%0d other %0d expected %0d done@%0d other 0",
                  dcnt, done_at, other, D_DEATH, D_DEATH + 1);
      end
   endtask

   task automatic test_death_ignores();
      int dcnt = 0;
      int other = 0;
      for (int i = 1; i <= 12; i++) begin
         step(i == 3, i == 2, (i == 1) || (i == 4), 4'd2, 0, 0);
         n_checks++;
         if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL death_ignore step %0d: got %b expected %b", i, act, exp_vec());
         end
         if (sound_death) dcnt++;
         if (sound_start || sound_eatghost) other++;
      end
      n_checks++;
      if (dcnt !== D_DEATH || other !== 0) begin
         n_fail++;
         $display("FAIL death_ignore_len: got death %0d other %0d expected %0d other 0", dcnt, other, D_DEATH);
      end
   endtask

   task automatic test_retrigger_mute();
      int busy_cnt = 0;
      logic [3:0] ct;
      for (int i = 0; i < 16; i++) begin
         ct = (i < 10) ? ((((i / 2) % 2) == 0) ? 4'd3 : 4'd2) : 4'd3;
         step(0, 0, 0, ct, (i == 4) || (i == 5), 0);
         n_checks++;
         if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL retrigger step %0d: got %b expected %b", i, act, exp_vec());
         end
         if (i == 4 || i == 5) begin
            n_checks++;
            if (sound_chomp !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL mute_gate step %0d: got chomp %b busy %b expected chomp 0 busy 1", i, sound_chomp, busy);
            end
         end
         if (busy) busy_cnt++;
      end
      n_checks++;
      if (busy_cnt !== 8 + D_CHOMP) begin
         n_fail++;
         $display("FAIL retrigger_len: got busy %0d expected %0d", busy_cnt, 8 + D_CHOMP);
      end
   endtask

   task automatic test_reset_mid_death();
      int done_seen = 0;
      for (int i = 1; i <= 3; i++) step(0, 0, i == 1, 4'd0, 0, 0);
      n_checks++;
      if (sound_death !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid pre: got death %b expected 1", sound_death);
      end
      step(0, 0, 0, 4'd0, 0, 1);
      n_checks++;
      if (act !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got %b expected %b", act, 6'b0);
      end
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 4'd0, 0, 0);
         n_checks++;
         if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mid after step %0d: got %b expected %b", i, act, exp_vec());
         end
         if (death_done) done_seen++;
      end
      n_checks++;
      if (done_seen !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_done: got %0d pulses expected 0", done_seen);
      end
   endtask

   task automatic test_random();
      logic [3:0] ct = 4'd0;
      bit m = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) ct = 4'($urandom_range(0, 4));
         if ($urandom_range(0, 20) == 0) m = ~m;
         step($urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 39) == 0, ct, m, $urandom_range(0, 199) == 0);
         n_checks++;
         if (act !== exp_vec()) begin
            n_fail++;
            $display("FAIL random step %0d: got %b expected %b", i, act, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_chomp();
      test_preempt();
      test_same_cycle();
      test_death_ignores();
      test_retrigger_mute();
      test_reset_mid_death();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
